// File: rtl/picosoc_bus_fabric.sv
// PicoRV32 native-bus fabric: decodes CPU requests to RAM, SPI flash, MMIO slaves or the
// internal GPIO block, answers through a registered IDLE/EXT/RESP FSM with a hang watchdog.
module picosoc_bus_fabric #(
    parameter int unsigned MEM_WORDS = 512,
    parameter int unsigned GPIO_W    = 16,
    parameter int unsigned NSLV      = 4,
    parameter logic [31:0] SLV_BASE  = 32'h0200_0000,
    parameter logic [31:0] SLV_SPAN  = 32'h0000_0100,
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 mem_valid,
    input  logic                 mem_instr,
    output logic                 mem_ready,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic [31:0]          mem_rdata,
    input  logic [31:0]          ram_rdata,
    output logic [3:0]           ram_gwenb,
    output logic [31:0]          ram_wenb,
    output logic                 spimem_valid,
    input  logic                 spimem_ready,
    input  logic [31:0]          spimem_rdata,
    output logic [NSLV-1:0]      slv_valid,
    input  logic [NSLV-1:0]      slv_ready,
    input  logic [32*NSLV-1:0]   slv_rdata,
    input  logic [GPIO_W-1:0]    gpio_in,
    output logic [GPIO_W-1:0]    gpio_out,
    output logic [GPIO_W-1:0]    gpio_oeb,
    output logic                 bus_err
);
    localparam logic [31:0] RAM_TOP = 32'(4 * MEM_WORDS);
    localparam int SLV_IW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_RESP} state_e;
    typedef enum logic [1:0] {T_RAM, T_FLASH, T_SLV, T_LAT} tgt_e;

    state_e              state_q, state_d;
    tgt_e                tgt_q, tgt_d;
    logic [SLV_IW-1:0]   sidx_q, sidx_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [GPIO_W-1:0]   data_q, data_d, oe_q, oe_d, sync1_q, sync2_q;
    logic                bus_err_q, bus_err_d;

    logic                hit_ram, hit_flash, hit_slv, in_io, hit_reg, req_err;
    logic [SLV_IW-1:0]   slv_sel;
    logic [31:0]         reg_rdata, wmask;
    logic                reg_we, err_set, sts_clr;
    logic                ext_ready;
    logic [31:0]         ext_rdata;

    always_comb begin
        hit_ram   = mem_addr < RAM_TOP;
        hit_flash = (mem_addr >= RAM_TOP) && (mem_addr < SLV_BASE);
        hit_slv   = 1'b0;
        slv_sel   = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (mem_addr >= SLV_BASE + 32'(i) * SLV_SPAN &&
                mem_addr <  SLV_BASE + 32'(i + 1) * SLV_SPAN) begin
                hit_slv = 1'b1;
                slv_sel = SLV_IW'(i);
            end
        end
        in_io   = mem_addr[31:24] == 8'h03;
        hit_reg = in_io && (mem_addr[23:4] == 20'd0) && (mem_addr[1:0] == 2'd0);
        // fetches never target peripheral space; anything outside the decoded windows is an error
        req_err = (mem_instr && (in_io || hit_slv)) || !(hit_flash || hit_slv || hit_reg);
    end

    always_comb begin
        case (mem_addr[3:2])
            2'd0:    reg_rdata = 32'(data_q);
            2'd1:    reg_rdata = 32'(oe_q);
            2'd2:    reg_rdata = 32'(sync2_q);
            default: reg_rdata = {31'd0, bus_err_q};
        endcase
        wmask   = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
        reg_we  = (state_q == S_IDLE) && mem_valid && !hit_ram && hit_reg && !mem_instr &&
                  (mem_wstrb != 4'd0);
        data_d  = data_q;
        oe_d    = oe_q;
        if (reg_we && mem_addr[3:2] == 2'd0)
            data_d = GPIO_W'((32'(data_q) & ~wmask) | (mem_wdata & wmask));
        if (reg_we && mem_addr[3:2] == 2'd1)
            oe_d = GPIO_W'((32'(oe_q) & ~wmask) | (mem_wdata & wmask));
        sts_clr = reg_we && (mem_addr[3:2] == 2'd3) && mem_wstrb[0] && mem_wdata[0];
    end

    always_comb begin
        ext_ready = (tgt_q == T_FLASH) ? spimem_ready : slv_ready[sidx_q];
        ext_rdata = (tgt_q == T_FLASH) ? spimem_rdata : slv_rdata[32*sidx_q +: 32];
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        sidx_d  = sidx_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    if (hit_ram) begin
                        tgt_d   = T_RAM;
                        state_d = S_RESP;
                    end else if (req_err) begin
                        tgt_d   = T_LAT;
                        rdata_d = ERR_DATA;
                        err_set = 1'b1;
                        state_d = S_RESP;
                    end else if (hit_reg) begin
                        tgt_d   = T_LAT;
                        rdata_d = reg_rdata;
                        state_d = S_RESP;
                    end else begin
                        tgt_d   = hit_flash ? T_FLASH : T_SLV;
                        sidx_d  = slv_sel;
                        cnt_d   = '0;
                        state_d = S_EXT;
                    end
                end
            end
            S_EXT: begin
                if (ext_ready) begin
                    tgt_d   = T_LAT;
                    rdata_d = ext_rdata;
                    state_d = S_RESP;
                end else if (TIMEOUT > 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                    tgt_d   = T_LAT;
                    rdata_d = ERR_DATA;
                    err_set = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // a new error outranks a simultaneous write-1-clear
        bus_err_d = err_set ? 1'b1 : (sts_clr ? 1'b0 : bus_err_q);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            tgt_q     <= T_RAM;
            data_q    <= '0;
            oe_q      <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            data_q    <= data_d;
            oe_q      <= oe_d;
            sync1_q   <= gpio_in;
            sync2_q   <= sync1_q;
            bus_err_q <= bus_err_d;
        end
    end

    always_ff @(posedge clk) begin
        sidx_q  <= sidx_d;
        rdata_q <= rdata_d;
        cnt_q   <= cnt_d;
    end

    // outputs are gated by resetn so an in-flight access is dropped as soon as reset asserts
    always_comb begin
        mem_ready    = resetn && (state_q == S_RESP);
        mem_rdata    = '0;
        if (mem_ready)
            mem_rdata = (tgt_q == T_RAM) ? ram_rdata : rdata_q;
        ram_gwenb    = 4'hF;
        if (resetn && state_q == S_IDLE && mem_valid && hit_ram)
            ram_gwenb = ~mem_wstrb;
        ram_wenb     = {{8{ram_gwenb[3]}}, {8{ram_gwenb[2]}}, {8{ram_gwenb[1]}}, {8{ram_gwenb[0]}}};
        spimem_valid = resetn && (state_q == S_EXT) && (tgt_q == T_FLASH);
        slv_valid    = '0;
        if (resetn && state_q == S_EXT && tgt_q == T_SLV)
            slv_valid[sidx_q] = 1'b1;
    end

    assign gpio_out = data_q;
    assign gpio_oeb = ~oe_q;
    assign bus_err  = bus_err_q;
endmodule
